// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the iterative multiplier controller.
package mul_pkg;

    localparam int MULCYCLES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iter_state_t;

endpackage

// File: rtl/mul_step_cnt.sv
// Iteration step counter with synchronous clear and a terminal-match compare.
module mul_step_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] compare,
    output logic [CNT_W-1:0] count,
    output logic             match
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign match = (count == compare);

endmodule

// File: rtl/mul_iter_ctrl.sv
// Iteration controller for a multi-cycle multiplier: IDLE -> RUN (N steps) -> DONE handshake.
// Optional cancel input enabled by defining MUL_ITER_ABORT_EN.
module mul_iter_ctrl
    import mul_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DEF_CYCLES = mul_pkg::MULCYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles_i,
`ifdef MUL_ITER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             done_ready,
    output logic             busy,
    output logic [CNT_W-1:0] step,
    output logic             first,
    output logic             last,
    output logic             done,
    output logic             err
);

    // The counter exits at N-1, so N must fit below the all-ones count.
    if (DEF_CYCLES < 1 || DEF_CYCLES > (1 << CNT_W) - 1) begin : g_bad_def_cycles
        $error("mul_iter_ctrl: DEF_CYCLES out of range for CNT_W");
    end

    iter_state_t      state, state_nx;
    logic [CNT_W-1:0] n_q, n_nx, n_sel, n_last;
    logic [CNT_W-1:0] count;
    logic             match;
    logic             cnt_clear, cnt_en;
    logic             err_c;
    logic             abort_act;

`ifdef MUL_ITER_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign n_sel  = (cycles_i == '0) ? CNT_W'(DEF_CYCLES) : cycles_i;
    assign n_last = n_q - CNT_W'(1);

    always_comb begin
        state_nx  = state;
        n_nx      = n_q;
        cnt_clear = 1'b0;
        err_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = RUN;
                    n_nx      = n_sel;
                    cnt_clear = 1'b1;
                end
            end
            RUN: begin
                if (abort_act) begin
                    state_nx  = IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    err_c = start;
                    if (match) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_act) begin
                    state_nx  = IDLE;
                    cnt_clear = 1'b1;
                end else if (done_ready) begin
                    cnt_clear = 1'b1;
                    // Accepting a result and starting the next one share a cycle.
                    if (start) begin
                        state_nx = RUN;
                        n_nx     = n_sel;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    err_c = start;
                end
            end
            default: begin
                state_nx  = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n_q   <= '0;
        end else begin
            state <= state_nx;
            n_q   <= n_nx;
        end
    end

    assign cnt_en = (state == RUN) && !match && !abort_act;

    mul_step_cnt #(
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk     (clk),
        .clear   (cnt_clear || rst),
        .enable  (cnt_en),
        .compare (n_last),
        .count   (count),
        .match   (match)
    );

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign step  = count;
    assign first = busy && (count == '0);
    assign last  = busy && match;
    assign err   = err_c && !rst;

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Scoreboard bench for mul_iter_ctrl: timestamp-based reference model, directed plus random stimulus.
module tb_mul_iter_ctrl;
    import mul_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cycles_i = '0;
    logic          abort = 1'b0;
    logic          done_ready = 1'b0;
    logic          busy, first, last, done, err;
    logic [CW-1:0] step;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mul_iter_ctrl #(
        .CNT_W      (CW),
        .DEF_CYCLES (MULCYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cycles_i   (cycles_i),
`ifdef MUL_ITER_ABORT_EN
        .abort      (abort),
`endif
        .done_ready (done_ready),
        .busy       (busy),
        .step       (step),
        .first      (first),
        .last       (last),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit busy;
        bit done;
        bit first;
        bit last;
        bit err;
        int step;
    } exp_t;

    typedef struct {
        int at;
        int n;
    } done_t;

    exp_t  cyc_q[$];
    done_t done_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    // Reference model: one operation at a time, described by when it started and its length.
    bit m_active = 1'b0;
    int m_t0 = 0;
    int m_n = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic accept(input int nsel);
        m_active = 1'b1;
        m_t0     = cyc;
        m_n      = nsel;
        done_q.push_back('{at: cyc + nsel + 1, n: nsel});
    endtask

    task automatic drive(input bit st, input int cy, input bit dr, input bit rs, input bit ab);
        exp_t e;
        int   k;
        int   nsel;
        bit   in_run;
`ifndef MUL_ITER_ABORT_EN
        ab = 1'b0;
`endif
        start      = st;
        cycles_i   = cy[CW-1:0];
        done_ready = dr;
        rst        = rs;
        abort      = ab;
        nsel   = (cycles_i == '0) ? MULCYCLES : int'(cycles_i);
        k      = cyc - m_t0;
        in_run = m_active && (k <= m_n);
        e = '{busy: 1'b0, done: 1'b0, first: 1'b0, last: 1'b0, err: 1'b0, step: 0};
        if (in_run) begin
            e.busy  = 1'b1;
            e.step  = k - 1;
            e.first = (k == 1);
            e.last  = (k == m_n);
            e.err   = st && !rs && !ab;
        end else if (m_active) begin
            e.done = 1'b1;
            e.step = m_n - 1;
            e.err  = st && !dr && !rs && !ab;
        end
        cyc_q.push_back(e);
        if (rs || (m_active && ab)) begin
            if (in_run && done_q.size() > 0) done_q.delete(done_q.size() - 1);
            m_active = 1'b0;
        end else if (!m_active) begin
            if (st) accept(nsel);
        end else if (!in_run && dr) begin
            if (st) accept(nsel);
            else m_active = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 15), dr, 1'b0, 1'b0);
    endtask

    exp_t  me;
    done_t md;
    bit    done_d = 1'b0;

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            me = cyc_q.pop_front();
            chk("busy", int'(busy), int'(me.busy));
            chk("done", int'(done), int'(me.done));
            chk("first", int'(first), int'(me.first));
            chk("last", int'(last), int'(me.last));
            chk("err", int'(err), int'(me.err));
            chk("step", int'(step), me.step);
            if (done === 1'b1 && !done_d) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1, expected no pending result", cyc);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", cyc, md.at);
                    chk("done_step", int'(step), md.n - 1);
                end
            end
        end
        done_d <= (done === 1'b1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5, 1'b1, 1'b1, 1'b0);

        // N=5, done held three cycles before acceptance
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // cycles_i=0 selects the default count
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(MULCYCLES, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // single-iteration run
        drive(1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // start ignored at step 2 with a different cycles_i
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(1'b1, 7, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // back-to-back restart from DONE with N=3
        drive(1'b1, 4, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // reset at step 3 overriding start
        drive(1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

`ifdef MUL_ITER_ABORT_EN
        drive(1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 2, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
        end

        idle(20, 1'b1);
        chk("done_queue_empty", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_iter_ctrl.md
MUL_ITER_CTRL -- requirements
Module: mul_iter_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, giving the step-counter and cycle-count width.
REQ-002 SHALL have parameter DEF_CYCLES, default mul_pkg::MULCYCLES, giving the iteration count used when cycles_i is 0.
REQ-003 SHALL have one clock and a synchronous active-high reset:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a new multiplication.
- cycles_i  in  CNT_W  iteration count N; 0 selects DEF_CYCLES.
- abort  in  1  cancel the current operation (only when MUL_ITER_ABORT_EN is defined).
- done_ready  in  1  consumer accepts done.
- busy  out  1  iterations in progress.
- step  out  CNT_W  current iteration index.
- first  out  1  high on iteration 0.
- last  out  1  high on iteration N-1.
- done  out  1  result valid; held until accepted.
- err  out  1  one-cycle pulse when start is ignored.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE, with the state type taken from mul_pkg.
REQ-005 IDLE SHALL behave as follows:
- busy=0, done=0, step=0.
- start=1 latches N (cycles_i, or DEF_CYCLES if cycles_i==0).
- start=1 clears step and moves to RUN on the next edge.
REQ-006 RUN SHALL behave as follows:
- busy=1; step increments by 1 per cycle starting from 0.
- first=(step==0); last=(step==N-1).
- On the cycle last=1, the next state is DONE.
REQ-007 Latency: with start sampled at edge t, busy SHALL be high for cycles t+1..t+N and done SHALL first be high in cycle t+N+1.
REQ-008 N=1 SHALL give first=last=1 in the single RUN cycle.
REQ-009 DONE SHALL behave as follows:
- done=1, busy=0; step holds N-1.
- Leaves for IDLE when done_ready=1.
REQ-010 In DONE, start=1 together with done_ready=1 SHALL go straight to RUN with the new N (back-to-back, no IDLE bubble).
REQ-011 start=1 in RUN, or in DONE without done_ready, SHALL be ignored: err=1 for exactly that cycle, and state and N are unchanged.
REQ-012 Latched N SHALL NOT change while in RUN, whatever cycles_i does.
REQ-013 The step counter SHALL never wrap, since exit at N-1 precedes the maximum value 2^CNT_W-1.
REQ-014 Elaboration SHALL fail if DEF_CYCLES is 0 or is greater than 2^CNT_W-1.
REQ-015 first, last and err SHALL be 0 outside RUN, except err per REQ-011.

Reset
REQ-016 rst=1 SHALL force IDLE on the next edge and clear N, step and err.
REQ-017 Reset SHALL give busy=0, done=0, first=0, last=0, err=0, step=0.
REQ-018 Reset mid-RUN or in DONE SHALL discard the operation with no done pulse, and rst SHALL override start.

Configuration
REQ-019 Macro MUL_ITER_ABORT_EN SHALL control the abort feature.
REQ-020 With MUL_ITER_ABORT_EN defined, abort behaves as follows:
- abort=1 in RUN or DONE returns to IDLE next edge, clearing done and step.
- abort has priority over start and done_ready.
- abort=1 in IDLE is ignored.
REQ-021 With MUL_ITER_ABORT_EN undefined, the abort port SHALL be absent and every operation runs to completion.

Structure
REQ-022 mul_pkg SHALL hold MULCYCLES and typedef enum iter_state_t {IDLE, RUN, DONE}.
REQ-023 The step counter SHALL be a sub-module mul_step_cnt:
- Parameter CNT_W; inputs clear and enable.
- Output count and a terminal-match flag against a compare input.
- The FSM lives in mul_iter_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- CNT_W=4, cycles_i=5, start at cycle 0 -> busy cycles 1..5; step 0..4; first at cycle 1; last at cycle 5; done at cycle 6, held until done_ready.
- cycles_i=0 -> exactly MULCYCLES RUN cycles; done at MULCYCLES+1.
- cycles_i=1 -> one RUN cycle with first=last=1.
- start pulsed at step 2 of an N=5 run -> err=1 for that cycle; done still at cycle 6.
- In DONE, start and done_ready together with cycles_i=3 -> RUN next cycle; done 4 cycles later.
- rst=1 at step 3, and (abort build) abort=1 at step 3 -> IDLE next edge; no done; step=0.
